// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl -- iterative AES inverse cipher, one round per clock.
//
// The caller supplies round keys: the block drives rk_idx and expects rk
// for that index in the same cycle. A block is accepted in IDLE, runs
// NR-1 full inverse rounds in ROUND and the last round in FINAL, then
// waits in DONE until the consumer takes out_data.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     ciphertext handshake, in_data[0:127] (byte0 = bits 0:7)
//   rk_idx, rk[0:127]     round-key request / combinational key response
//   rk_valid              (AES_INV_KEY_WAIT_EN only) key present this cycle
//   out_valid/out_ready   plaintext handshake, out_data[0:127]
//   busy                  any state other than IDLE
//
// Optional feature: define AES_INV_KEY_WAIT_EN to add rk_valid; acceptance
// and every round then stall in cycles where the key is not available.

module aes_inv_cipher_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk,
`ifdef AES_INV_KEY_WAIT_EN
    input  logic         rk_valid,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // GF(2^8) multiply by a constant c (only 9, b, d, e are used) via xtime chain
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? b  : 8'h00);
    endfunction

    // InvSubBytes(InvShiftRows(s)); byte (row r, col c) sits at index 4c+r,
    // and row r is rotated right by r columns
    function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = INV_SBOX[s[8*(4*((c-r+4)%4)+r) +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] inv_mix(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c    +: 8];
            a1 = s[32*c+8  +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[32*c+8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[32*c+16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[32*c+24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [0:127] st;
    logic         rk_ok;

`ifdef AES_INV_KEY_WAIT_EN
    assign rk_ok = rk_valid;
`else
    assign rk_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
            cnt <= '0;
            st  <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid && rk_ok) begin
                    st  <= in_data ^ rk;
                    cnt <= NR_M1;
                    fsm <= ROUND;
                end
                ROUND: if (rk_ok) begin
                    st  <= inv_mix(inv_shift_sub(st) ^ rk);
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: if (rk_ok) begin
                    st  <= inv_shift_sub(st) ^ rk;
                    fsm <= DONE;
                end
                DONE: if (out_ready) fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

    always_comb begin
        rk_idx = 4'd0;
        case (fsm)
            IDLE:    rk_idx = NR_IDX;
            ROUND:   rk_idx = cnt;
            default: rk_idx = 4'd0;
        endcase
    end

    // in_ready also waits for the key so the handshake means "accepted"
    assign in_ready  = (fsm == IDLE) && rk_ok;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_data  = st;

endmodule
